// File: rtl/spad_pkg.sv
// -----------------------------------------------------------------------------
// spad_pkg
// Shared definitions for the address scratchpad blocks.
//   ZERO_END    : data value that marks the end of an address vector
//   SPAD_DATA_W : default address entry width
//   SPAD_DEPTH  : default entries per bank
//   bank_idx_t  : index of one of the two ping-pong banks
//   other_bank  : returns the opposite bank of a ping-pong pair
// -----------------------------------------------------------------------------
package spad_pkg;

    localparam int ZERO_END    = 0;
    localparam int SPAD_DATA_W = 7;
    localparam int SPAD_DEPTH  = 32;

    typedef logic bank_idx_t;

    function automatic bank_idx_t other_bank(input bank_idx_t b);
        return ~b;
    endfunction

endpackage

// File: rtl/addr_spad_bank.sv
// -----------------------------------------------------------------------------
// addr_spad_bank
// One scratchpad bank: DEPTH x DATA_W storage, one synchronous write port and
// one asynchronous (combinational) read port. Contents are not reset; the
// parent only exposes a bank after a full vector has been committed to it.
// Ports:
//   i_clk    : clock, rising edge
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address
//   o_rdata  : read data (combinational)
// -----------------------------------------------------------------------------
module addr_spad_bank
    import spad_pkg::*;
#(
    parameter int DATA_W = SPAD_DATA_W,
    parameter int DEPTH  = SPAD_DEPTH
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [DATA_W-1:0]        o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Storage write port; intentionally without reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/csc_addr_spad.sv
// -----------------------------------------------------------------------------
// csc_addr_spad
// Ping-pong address scratchpad: two banks, one filled by the writer while the
// other is read. A vector ends with a zero entry or at the last address.
// Optional feature macro: ADDR_SPAD_OVF_CHK_EN adds the sticky 'ovf' output,
// set when a vector is cut off at the last address with a non-zero entry.
// Ports:
//   clock, reset_n          : clock (rising edge), async active-low reset
//   data_in/_valid/write_en : write beat; accepted when data_in_ready is high
//   data_in_ready           : write bank is free
//   write_fin               : combinational pulse on the committing beat
//   data_out/_valid         : current read entry of a committed bank
//   addr_read_inc           : advance read pointer
//   read_idx/read_idx_en    : load read pointer (wins over addr_read_inc)
//   read_keep               : keep bank committed at end of vector
//   read_fin                : combinational pulse at end of vector
//   bank_full               : per-bank committed flags
//   ovf                     : (macro only) sticky truncation flag
// -----------------------------------------------------------------------------
module csc_addr_spad
    import spad_pkg::*;
#(
    parameter int DATA_W = SPAD_DATA_W,
    parameter int DEPTH  = SPAD_DEPTH
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     data_in_valid,
    input  logic                     write_en,
    output logic                     data_in_ready,
    output logic                     write_fin,
    output logic [DATA_W-1:0]        data_out,
    output logic                     data_out_valid,
    input  logic                     addr_read_inc,
    input  logic [$clog2(DEPTH)-1:0] read_idx,
    input  logic                     read_idx_en,
    input  logic                     read_keep,
    output logic                     read_fin,
    output logic [1:0]               bank_full
`ifdef ADDR_SPAD_OVF_CHK_EN
    ,
    output logic                     ovf
`endif
);

    localparam int                IDX_W     = $clog2(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_ADDR = IDX_W'(DEPTH - 1);
    localparam logic [DATA_W-1:0] ZERO_WORD = DATA_W'(ZERO_END);

    bank_idx_t         r_wr_bank;
    bank_idx_t         r_rd_bank;
    logic [IDX_W-1:0]  r_wr_addr;
    logic [IDX_W-1:0]  r_rd_addr;
    logic [1:0]        r_bank_full;

    logic              w_ready;
    logic              w_shake;
    logic              w_commit;
    logic              w_valid;
    logic              w_rd_active;
    logic              w_eov;
    logic              w_release;
    logic [DATA_W-1:0] w_rd_word;
    logic [DATA_W-1:0] w_data_out;
    logic [DATA_W-1:0] w_rdata0;
    logic [DATA_W-1:0] w_rdata1;
    logic [1:0]        w_bank_full_nxt;
    logic              w_we0;
    logic              w_we1;

    assign w_we0 = w_shake & (r_wr_bank == 1'b0);
    assign w_we1 = w_shake & (r_wr_bank == 1'b1);

    addr_spad_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_bank0 (
        .i_clk   (clock),
        .i_we    (w_we0),
        .i_waddr (r_wr_addr),
        .i_wdata (data_in),
        .i_raddr (r_rd_addr),
        .o_rdata (w_rdata0)
    );

    addr_spad_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_bank1 (
        .i_clk   (clock),
        .i_we    (w_we1),
        .i_waddr (r_wr_addr),
        .i_wdata (data_in),
        .i_raddr (r_rd_addr),
        .o_rdata (w_rdata1)
    );

    // Handshake, commit, read-side qualification and end-of-vector decode.
    // Beats are gated by reset_n so write_fin/read_fin stay low during reset.
    always_comb begin
        w_ready   = ~r_bank_full[r_wr_bank];
        w_shake   = reset_n & data_in_valid & write_en & w_ready;
        w_commit  = w_shake & ((data_in == ZERO_WORD) | (r_wr_addr == LAST_ADDR));
        w_valid   = r_bank_full[r_rd_bank];
        if (r_rd_bank == 1'b1) begin
            w_rd_word = w_rdata1;
        end else begin
            w_rd_word = w_rdata0;
        end
        // An uncommitted bank must never leak onto data_out.
        w_data_out  = w_valid ? w_rd_word : ZERO_WORD;
        w_eov       = (w_data_out == ZERO_WORD) | (r_rd_addr == LAST_ADDR);
        w_rd_active = reset_n & addr_read_inc & w_valid & ~read_idx_en;
        w_release   = w_rd_active & w_eov & ~read_keep;
    end

    // Next committed flags: commit and release always hit different banks.
    always_comb begin
        w_bank_full_nxt = r_bank_full;
        for (int b = 0; b < 2; b++) begin
            w_bank_full_nxt[b] = (w_commit  && (r_wr_bank == 1'(b))) ? 1'b1 :
                                 (w_release && (r_rd_bank == 1'(b))) ? 1'b0 :
                                 r_bank_full[b];
        end
    end

    // Write pointer and write bank selection.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_addr <= {IDX_W{1'b0}};
            r_wr_bank <= 1'b0;
        end else if (w_commit) begin
            r_wr_addr <= {IDX_W{1'b0}};
            r_wr_bank <= other_bank(r_wr_bank);
        end else if (w_shake) begin
            r_wr_addr <= r_wr_addr + IDX_W'(1);
        end
    end

    // Read pointer and read bank selection; an index load wins over increment.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_addr <= {IDX_W{1'b0}};
            r_rd_bank <= 1'b0;
        end else begin
            if (read_idx_en) begin
                r_rd_addr <= read_idx;
            end else if (w_rd_active) begin
                r_rd_addr <= w_eov ? {IDX_W{1'b0}} : (r_rd_addr + IDX_W'(1));
            end
            if (w_release) begin
                r_rd_bank <= other_bank(r_rd_bank);
            end
        end
    end

    // Per-bank committed flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_bank_full <= 2'b00;
        end else begin
            r_bank_full <= w_bank_full_nxt;
        end
    end

`ifdef ADDR_SPAD_OVF_CHK_EN
    logic r_ovf;

    // Sticky flag: vector truncated at the last address with a non-zero entry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf <= 1'b0;
        end else if (w_commit && (r_wr_addr == LAST_ADDR) && (data_in != ZERO_WORD)) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf = r_ovf;
`endif

    assign data_in_ready  = w_ready;
    assign write_fin      = w_commit;
    assign data_out       = w_data_out;
    assign data_out_valid = w_valid;
    assign read_fin       = w_rd_active & w_eov;
    assign bank_full      = r_bank_full;

endmodule

// File: tb/tb_csc_addr_spad.sv
// -----------------------------------------------------------------------------
// tb_csc_addr_spad
// Scoreboard bench: stimulus pushes expected write_fin per write beat and
// expected {data_out, read_fin} per read beat; a monitor on the falling edge
// pops and compares whenever the DUT presents a beat. Status flags are
// checked directly by the stimulus at fixed points.
// -----------------------------------------------------------------------------
module tb_csc_addr_spad;

    localparam int DATA_W = 7;
    localparam int DEPTH  = 32;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              data_in_valid = 1'b0;
    logic              write_en = 1'b0;
    logic              data_in_ready;
    logic              write_fin;
    logic [DATA_W-1:0] data_out;
    logic              data_out_valid;
    logic              addr_read_inc = 1'b0;
    logic [4:0]        read_idx = '0;
    logic              read_idx_en = 1'b0;
    logic              read_keep = 1'b0;
    logic              read_fin;
    logic [1:0]        bank_full;
`ifdef ADDR_SPAD_OVF_CHK_EN
    logic              ovf;
`endif

    int checks = 0;
    int errors = 0;

    bit         wq[$];
    logic [7:0] rq[$];

    csc_addr_spad #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .write_en       (write_en),
        .data_in_ready  (data_in_ready),
        .write_fin      (write_fin),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .addr_read_inc  (addr_read_inc),
        .read_idx       (read_idx),
        .read_idx_en    (read_idx_en),
        .read_keep      (read_keep),
        .read_fin       (read_fin),
        .bank_full      (bank_full)
`ifdef ADDR_SPAD_OVF_CHK_EN
        ,
        .ovf            (ovf)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every presented beat against the scoreboard queues.
    always @(negedge clock) begin
        if (reset_n) begin
            if (data_in_valid && write_en && data_in_ready) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write_beat", 32'd1, 32'd0);
                end else begin
                    chk("write_fin", {31'd0, write_fin}, {31'd0, wq.pop_front()});
                end
            end else begin
                chk("write_fin_idle", {31'd0, write_fin}, 32'd0);
            end
            if (addr_read_inc && data_out_valid && !read_idx_en) begin
                if (rq.size() == 0) begin
                    chk("unexpected_read_beat", 32'd1, 32'd0);
                end else begin
                    chk("read_beat", {24'd0, data_out, read_fin}, {24'd0, rq.pop_front()});
                end
            end else begin
                chk("read_fin_idle", {31'd0, read_fin}, 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        data_in_valid = 1'b0;
        write_en      = 1'b0;
        data_in       = '0;
        addr_read_inc = 1'b0;
        read_idx_en   = 1'b0;
        read_keep     = 1'b0;
    endtask

    task automatic wr_set(input logic [6:0] d, input bit fin);
        data_in       = d;
        data_in_valid = 1'b1;
        write_en      = 1'b1;
        wq.push_back(fin);
    endtask

    task automatic rd_set(input logic [6:0] d, input bit fin, input bit keep);
        addr_read_inc = 1'b1;
        read_keep     = keep;
        rq.push_back({d, fin});
    endtask

    task automatic wr(input logic [6:0] d, input bit fin);
        wr_set(d, fin);
        step();
    endtask

    task automatic rd(input logic [6:0] d, input bit fin, input bit keep);
        rd_set(d, fin, keep);
        step();
    endtask

    // Assert reset with active-looking inputs, check reset outputs, release.
    task automatic do_reset();
        reset_n       = 1'b0;
        data_in       = '0;
        data_in_valid = 1'b1;
        write_en      = 1'b1;
        addr_read_inc = 1'b1;
        #2;
        chk("rst_data_out", {25'd0, data_out}, 32'd0);
        chk("rst_valid", {31'd0, data_out_valid}, 32'd0);
        chk("rst_ready", {31'd0, data_in_ready}, 32'd1);
        chk("rst_write_fin", {31'd0, write_fin}, 32'd0);
        chk("rst_read_fin", {31'd0, read_fin}, 32'd0);
        chk("rst_bank_full", {30'd0, bank_full}, 32'd0);
`ifdef ADDR_SPAD_OVF_CHK_EN
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
        idle();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        idle();
        #3;
        do_reset();

        // Single vector.
        wr(7'd3, 1'b0); wr(7'd5, 1'b0); wr(7'd9, 1'b0); wr(7'd0, 1'b1);
        idle();
        chk("single_full", {30'd0, bank_full}, 32'd1);
        rd(7'd3, 1'b0, 1'b0); rd(7'd5, 1'b0, 1'b0); rd(7'd9, 1'b0, 1'b0); rd(7'd0, 1'b1, 1'b0);
        idle();
        chk("single_released", {30'd0, bank_full}, 32'd0);

        // Ping-pong.
        do_reset();
        wr(7'd4, 1'b0); wr(7'd0, 1'b1);
        wr(7'd6, 1'b0); wr(7'd7, 1'b0); wr(7'd0, 1'b1);
        idle();
        chk("pp_both_full", {30'd0, bank_full}, 32'd3);
        chk("pp_ready_low", {31'd0, data_in_ready}, 32'd0);
        rd(7'd4, 1'b0, 1'b0);
        rd_set(7'd0, 1'b1, 1'b0);
        chk("pp_ready_low_at_release", {31'd0, data_in_ready}, 32'd0);
        step();
        chk("pp_ready_back", {31'd0, data_in_ready}, 32'd1);
        chk("pp_a_released", {30'd0, bank_full}, 32'd2);
        rd(7'd6, 1'b0, 1'b0); rd(7'd7, 1'b0, 1'b0); rd(7'd0, 1'b1, 1'b0);
        idle();
        chk("pp_all_released", {30'd0, bank_full}, 32'd0);

        // read_keep re-read.
        do_reset();
        wr(7'd2, 1'b0); wr(7'd8, 1'b0); wr(7'd0, 1'b1);
        idle();
        for (int p = 0; p < 3; p++) begin
            rd(7'd2, 1'b0, 1'b0); rd(7'd8, 1'b0, 1'b0); rd(7'd0, 1'b1, (p < 2));
            idle();
            chk("keep_full", {30'd0, bank_full}, (p < 2) ? 32'd1 : 32'd0);
        end

        // Depth boundary.
        do_reset();
        for (int i = 1; i <= DEPTH; i++) begin
            wr(7'(i), (i == DEPTH));
        end
        idle();
        chk("bnd_full", {30'd0, bank_full}, 32'd1);
`ifdef ADDR_SPAD_OVF_CHK_EN
        chk("bnd_ovf", {31'd0, ovf}, 32'd1);
`endif
        for (int i = 1; i <= DEPTH; i++) begin
            rd(7'(i), (i == DEPTH), 1'b0);
        end
        idle();
        chk("bnd_released", {30'd0, bank_full}, 32'd0);

        // Index load and simultaneous commit/release.
        do_reset();
        wr(7'd5, 1'b0); wr(7'd6, 1'b0); wr(7'd7, 1'b0); wr(7'd0, 1'b1);
        idle();
        read_idx      = 5'd2;
        read_idx_en   = 1'b1;
        addr_read_inc = 1'b1;
        #1;
        chk("idx_no_read_fin", {31'd0, read_fin}, 32'd0);
        step();
        read_idx_en = 1'b0;
        rd_set(7'd7, 1'b0, 1'b0); wr_set(7'd1, 1'b0);
        step();
        rd_set(7'd0, 1'b1, 1'b0); wr_set(7'd0, 1'b1);
        chk("sim_before", {30'd0, bank_full}, 32'd1);
        step();
        idle();
        chk("sim_after", {30'd0, bank_full}, 32'd2);

        // Reset mid-write, then a fresh vector lands in B0 from address 0.
        do_reset();
        wr(7'd7, 1'b0); wr(7'd8, 1'b0);
        idle();
        #2;
        do_reset();
        addr_read_inc = 1'b1;
        step(); step();
        idle();
        wr(7'd4, 1'b0); wr(7'd0, 1'b1);
        idle();
        chk("fresh_in_b0", {30'd0, bank_full}, 32'd1);
        rd(7'd4, 1'b0, 1'b0); rd(7'd0, 1'b1, 1'b0);
        idle();
        chk("fresh_released", {30'd0, bank_full}, 32'd0);

        step();
        chk("wq_drained", wq.size(), 32'd0);
        chk("rq_drained", rq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
